// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: data_ram geometry, host port session states
// and the default run-cycle limit.
package cpu_pkg;

  localparam int          CPU_ADDR_W         = 8;
  localparam int          CPU_DATA_W         = 8;
  localparam logic [15:0] DEFAULT_MAX_CYCLES = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    RUN,
    DUMP_RD,
    DUMP_OUT,
    DONE
  } host_state_t;

endpackage

// File: rtl/host_cycle_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags the count
// sitting at LIMIT so the owner can stop or report a timeout.
module host_cycle_counter #(
  parameter int           W     = 16,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         at_limit
);

  assign at_limit = (count == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_host_port.sv
// Host-side loader/runner/dumper for the CPU's data_ram: streams an image in,
// kicks the core, times the run, then streams a window of memory back out.
module mem_host_port
  import cpu_pkg::*;
#(
  parameter int          ADDR_W     = CPU_ADDR_W,
  parameter int          DATA_W     = CPU_DATA_W,
  parameter logic [15:0] MAX_CYCLES = DEFAULT_MAX_CYCLES,
  parameter int          KICK_LEN   = 2
) (
  input  logic              clk,
  input  logic              start,
  input  logic              go,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              cpu_start,
  input  logic              cpu_halt,
  output logic              mem_owner,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       cycles,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int KICK_W = (KICK_LEN > 1) ? $clog2(KICK_LEN) : 1;

  host_state_t       state, state_nxt;
  logic [ADDR_W-1:0] load_base_q, dump_base_q;
  logic [ADDR_W:0]   load_len_q, dump_len_q;
  logic [ADDR_W:0]   idx, idx_inc;
  logic [KICK_W-1:0] kick_cnt;
  logic [DATA_W-1:0] m_data_q;
  logic              fresh;
  logic              go_ok, load_hs, dump_hs, run_exit, at_limit;

  assign go_ok    = go && (state == IDLE || state == DONE);
  assign idx_inc  = idx + (ADDR_W+1)'(1);
  assign load_hs  = s_valid && s_ready;
  assign dump_hs  = (state == DUMP_OUT) && m_ready;
  assign run_exit = (state == RUN) && (cpu_halt || at_limit);

  // A write accepted in the same cycle as reset would land after the abort.
  assign s_ready   = (state == LOAD) && !start;
  assign mem_write = load_hs;
  assign mem_din   = load_hs ? s_data : '0;
  assign mem_read  = (state == DUMP_RD);
  assign m_valid   = (state == DUMP_OUT);
  assign cpu_start = (state != RUN);
  assign mem_owner = (state != RUN);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

  // RAM data is live on mem_dout only in the first DUMP_OUT cycle; after that
  // the registered copy keeps m_data stable across backpressure.
  assign m_data = fresh ? mem_dout : m_data_q;

  always_comb begin
    mem_addr = '0;
    if (state == LOAD) begin
      mem_addr = load_base_q + idx[ADDR_W-1:0];
    end else if (state == DUMP_RD) begin
      mem_addr = dump_base_q + idx[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (go) state_nxt = (load_len == '0) ? KICK : LOAD;
      LOAD:       if (load_hs && idx_inc == load_len_q) state_nxt = KICK;
      KICK:       if (kick_cnt == KICK_W'(KICK_LEN - 1)) state_nxt = RUN;
      RUN:        if (cpu_halt || at_limit) state_nxt = (dump_len_q == '0) ? DONE : DUMP_RD;
      DUMP_RD:    state_nxt = DUMP_OUT;
      DUMP_OUT:   if (m_ready) state_nxt = (idx_inc == dump_len_q) ? DONE : DUMP_RD;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state       <= IDLE;
      load_base_q <= '0;
      dump_base_q <= '0;
      load_len_q  <= '0;
      dump_len_q  <= '0;
      idx         <= '0;
      kick_cnt    <= '0;
      m_data_q    <= '0;
      fresh       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fresh    <= (state == DUMP_RD);
      kick_cnt <= (state == KICK) ? kick_cnt + KICK_W'(1) : '0;
      if (fresh) m_data_q <= mem_dout;
      if (go_ok) begin
        load_base_q <= load_base;
        dump_base_q <= dump_base;
        load_len_q  <= load_len;
        dump_len_q  <= dump_len;
        idx         <= '0;
        timeout     <= 1'b0;
      end else if (run_exit) begin
        idx     <= '0;
        timeout <= !cpu_halt;
      end else if (load_hs || dump_hs) begin
        idx <= idx_inc;
      end
    end
  end

  // The halt cycle itself is not counted, and a halt beats the limit.
  host_cycle_counter #(
    .W     (16),
    .LIMIT (MAX_CYCLES)
  ) u_run_counter (
    .clk      (clk),
    .rst      (start),
    .clear    (go_ok),
    .enable   ((state == RUN) && !cpu_halt),
    .count    (cycles),
    .at_limit (at_limit)
  );

endmodule

// File: tb/tb_mem_host_port.sv
// Randomised scoreboard bench for mem_host_port: drives load/run/dump sessions
// against a RAM, a stub core and a byte-level reference memory.
module tb_mem_host_port;

  localparam int          AW   = 8;
  localparam int          DW   = 8;
  localparam int          KL   = 2;
  localparam logic [15:0] MAXC = 16'd20;

  logic          clk = 1'b0;
  logic          start = 1'b1, go = 1'b0;
  logic [AW-1:0] load_base = '0, dump_base = '0;
  logic [AW:0]   load_len = '0, dump_len = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          cpu_start, cpu_halt = 1'b0;
  logic          mem_owner, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout = '0;
  logic [15:0]   cycles;
  logic          busy, done, timeout;

  always #5 clk = ~clk;

  mem_host_port #(.ADDR_W(AW), .DATA_W(DW), .MAX_CYCLES(MAXC), .KICK_LEN(KL)) dut (
    .clk(clk), .start(start), .go(go),
    .load_base(load_base), .load_len(load_len), .dump_base(dump_base), .dump_len(dump_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .cpu_start(cpu_start), .cpu_halt(cpu_halt),
    .mem_owner(mem_owner), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .cycles(cycles), .busy(busy), .done(done), .timeout(timeout)
  );

  int            n_checks = 0, n_fail = 0;
  logic [7:0]    env_ram[256];
  logic [7:0]    ref_mem[256];
  logic [15:0]   wr_q[$];
  logic [7:0]    dump_q[$];
  logic [7:0]    load_bytes[$];
  logic [15:0]   exp_wr;
  logic [7:0]    exp_byte, held;
  logic          held_valid = 1'b0;
  int            halt_delay = -1, run_cnt = 0, stall_len = 0, stall_cnt = 0, read_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // data_ram behind the top-level mux: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_owner && mem_write) env_ram[mem_addr] = mem_din;
    if (mem_owner && mem_read) mem_dout <= env_ram[mem_addr];
  end

  // Stub core: raises halt once, halt_delay cycles after cpu_start falls.
  always begin
    @(posedge clk); #1;
    if (cpu_start) begin
      run_cnt  = 0;
      cpu_halt = 1'b0;
    end else begin
      cpu_halt = (halt_delay >= 0) && (run_cnt == halt_delay);
      run_cnt++;
    end
  end

  // Host sink: holds m_ready low for stall_len cycles on every byte.
  always begin
    @(posedge clk); #1;
    if (m_valid) begin
      if (stall_cnt < stall_len) begin
        m_ready = 1'b0;
        stall_cnt++;
      end else begin
        m_ready   = 1'b1;
        stall_cnt = 0;
      end
    end else begin
      m_ready   = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor: pops expected writes and dump bytes as the DUT presents them.
  always @(negedge clk) begin
    if (mem_write) begin
      if (wr_q.size() == 0) begin
        checkOutput("wr_pending", wr_q.size(), 1);
      end else begin
        exp_wr = wr_q.pop_front();
        checkOutput("wr_addr", mem_addr, exp_wr[15:8]);
        checkOutput("wr_data", mem_din, exp_wr[7:0]);
        checkOutput("wr_owner", mem_owner, 1);
      end
    end
    if (mem_read) read_cnt++;
    if (!mem_owner) checkOutput("run_no_mem", {mem_read, mem_write}, 0);
    if (m_valid) begin
      if (held_valid) checkOutput("m_data_stable", m_data, held);
      if (m_ready) begin
        held_valid = 1'b0;
        if (dump_q.size() == 0) begin
          checkOutput("dump_pending", dump_q.size(), 1);
        end else begin
          exp_byte = dump_q.pop_front();
          checkOutput("dump_byte", m_data, exp_byte);
        end
      end else begin
        held       = m_data;
        held_valid = 1'b1;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] lb, input int ll, input logic [7:0] db, input int dl,
                               input int hd, input int stl, input bit poke, input bit fixed);
    int n, k, budget;
    logic [15:0] exp_cycles;
    logic [7:0] a;
    bit exp_to, poked;
    if (!fixed) begin
      load_bytes.delete();
      for (int i = 0; i < ll; i++) load_bytes.push_back(8'($urandom));
    end
    for (int i = 0; i < ll; i++) begin
      a = 8'(int'(lb) + i);
      wr_q.push_back({a, load_bytes[i]});
      ref_mem[a] = load_bytes[i];
    end
    for (int i = 0; i < dl; i++) dump_q.push_back(ref_mem[8'(int'(db) + i)]);
    if (hd >= 0 && hd <= int'(MAXC)) begin
      exp_cycles = 16'(hd);
      exp_to     = 1'b0;
    end else begin
      exp_cycles = MAXC;
      exp_to     = 1'b1;
    end
    halt_delay = hd;
    stall_len  = stl;
    read_cnt   = 0;
    @(posedge clk); #1;
    load_base = lb; load_len = 9'(ll); dump_base = db; dump_len = 9'(dl); go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0; budget = 0;
    while (n < ll && budget < 400) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = s_valid ? load_bytes[n] : 8'($urandom);
      if (s_valid && s_ready) n++;
      budget++;
      @(posedge clk); #1;
    end
    checkOutput("load_accepted", n, ll);
    s_valid = 1'($urandom);
    s_data  = 8'($urandom);
    k = 1;
    while (cpu_start && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("kick_len", k, KL + 1);
    poked = 1'b0; budget = 0;
    while (!done && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      go = 1'b0;
      if (poke && !poked && m_valid) begin
        go = 1'b1; poked = 1'b1; load_len = 9'd0; dump_len = 9'd1;
      end
    end
    go = 1'b0;
    s_valid = 1'b0;
    checkOutput("done", done, 1);
    checkOutput("cycles", cycles, exp_cycles);
    checkOutput("timeout", timeout, exp_to);
    checkOutput("busy_after", busy, 0);
    checkOutput("cpu_start_after", cpu_start, 1);
    checkOutput("mem_owner_after", mem_owner, 1);
    checkOutput("m_valid_after", m_valid, 0);
    checkOutput("read_count", read_cnt, dl);
    checkOutput("writes_left", wr_q.size(), 0);
    checkOutput("dump_left", dump_q.size(), 0);
  endtask

  task automatic resetMidLoad();
    int n, budget;
    logic [7:0] b[2];
    b[0] = 8'($urandom); b[1] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      wr_q.push_back({8'(8'hF0 + i), b[i]});
      ref_mem[8'(8'hF0 + i)] = b[i];
    end
    halt_delay = -1;
    @(posedge clk); #1;
    load_base = 8'hF0; load_len = 9'd4; dump_base = '0; dump_len = '0; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0; budget = 0;
    while (n < 2 && budget < 100) begin
      s_valid = 1'($urandom);
      s_data  = b[n];
      if (s_valid && s_ready) n++;
      budget++;
      @(posedge clk); #1;
    end
    checkOutput("abort_load_accepted", n, 2);
    start = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_cpu_start", cpu_start, 1);
    checkOutput("abort_mem_owner", mem_owner, 1);
    checkOutput("abort_s_ready", s_ready, 0);
    checkOutput("abort_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    checkOutput("abort_writes_left", wr_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_ram[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    env_ram[10] = 8'hA1; env_ram[11] = 8'hB2; env_ram[12] = 8'hC3;
    ref_mem[10] = 8'hA1; ref_mem[11] = 8'hB2; ref_mem[12] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cpu_start", cpu_start, 1);
    checkOutput("rst_mem_owner", mem_owner, 1);
    checkOutput("rst_cycles", cycles, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_din", mem_din, 0);
    start = 1'b0;

    resetMidLoad();

    load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(8'hFE, 4, 8'hFE, 4, 3, 1, 1'b0, 1'b1);
    applyStimulus(8'h00, 0, 8'h00, 0, 10, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 0, 8'h00, 0, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 0, 8'h00, 0, int'(MAXC), 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 0, 8'd10, 3, 5, 5, 1'b0, 1'b0);
    applyStimulus(8'h00, 0, 8'h80, 256, 7, 0, 1'b1, 1'b0);
    applyStimulus(8'h00, 0, 8'h00, 0, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      applyStimulus(8'($urandom), int'($urandom_range(0, 24)), 8'($urandom), int'($urandom_range(0, 24)),
                    int'($urandom_range(0, 26)) - 1, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_host_port.md
Name: mem_host_port

Overview:
- Host-side counterpart to the CPU's data_ram port: loads a byte image into data_ram, starts the core, and counts cycles until halt or timeout.
- After the run, it reads a window of data_ram back out to the host as a byte stream.
- Sits beside the CPU in the top level. It owns the data_ram port (through a top-level mux selected by mem_owner) whenever the core is not running.

Parameters:
- ADDR_W, 8, data_ram address width
- DATA_W, 8, data_ram / stream byte width
- MAX_CYCLES, 16'hFFFF, run-cycle limit before timeout
- KICK_LEN, 2, cycles cpu_start is held high

Ports:
- clk  in  1  clock
- start  in  1  synchronous active-high reset of this block
- go  in  1  one-cycle pulse that begins a session; sampled only in IDLE/DONE
- load_base  in  ADDR_W  first load address, latched on go
- load_len  in  ADDR_W+1  bytes to load (0..256), latched on go
- dump_base  in  ADDR_W  first dump address, latched on go
- dump_len  in  ADDR_W+1  bytes to dump (0..256), latched on go
- s_valid  in  1  load byte valid
- s_data  in  DATA_W  load byte
- s_ready  out  1  load byte accepted when s_valid&&s_ready
- m_valid  out  1  dump byte valid
- m_data  out  DATA_W  dump byte
- m_ready  in  1  host accepts dump byte
- cpu_start  out  1  drives the core's start input
- cpu_halt  in  1  core halt output
- mem_owner  out  1  1 = this block drives the data_ram port
- mem_read  out  1  data_ram read
- mem_write  out  1  data_ram write
- mem_addr  out  ADDR_W  data_ram address
- mem_din  out  DATA_W  data_ram write data
- mem_dout  in  DATA_W  data_ram read data, valid the cycle after mem_read
- cycles  out  16  run-cycle count, held after run
- busy  out  1  state != IDLE && state != DONE
- done  out  1  session complete
- timeout  out  1  run ended on MAX_CYCLES, not halt

Behaviour:
- Interface:
  - Clock is clk.
  - Reset is start: synchronous, active-high, sampled on posedge clk.
  - Reset wins over every other input.
- Reset values:
  - state=IDLE.
  - s_ready, m_valid, mem_read, mem_write, done, timeout, busy = 0.
  - cpu_start = 1 (core held in reset), mem_owner = 1.
  - cycles, m_data, mem_addr, mem_din = 0.
- Reset mid-session aborts immediately: no further mem writes, stream outputs drop next edge.
- FSM: IDLE -> LOAD -> KICK -> RUN -> DUMP_RD -> DUMP_OUT -> DONE.
- IDLE/DONE:
  - go latches config, clears cycles, done and timeout, and resets load/dump indices to 0.
  - Next state is LOAD, or KICK if load_len==0.
  - go in any other state is ignored.
- LOAD:
  - s_ready=1.
  - Each handshake writes mem_addr=load_base+idx (mod 2^ADDR_W, wraps) and mem_din=s_data with mem_write=1 in the same cycle. mem_write is combinational on the handshake.
  - After load_len handshakes -> KICK.
- KICK:
  - cpu_start=1 for KICK_LEN cycles; mem_owner=1; no mem access.
  - Then -> RUN with cpu_start=0.
- RUN:
  - mem_owner=0; mem_read=mem_write=0.
  - cycles increments each cycle, saturating at MAX_CYCLES.
  - cpu_halt=1 -> exit; the halt cycle is not counted.
  - cycles==MAX_CYCLES without halt -> timeout=1, exit.
  - Halt and limit in the same cycle: halt wins, timeout=0.
  - Exit goes to DUMP_RD, or DONE if dump_len==0.
  - On exit cpu_start returns to 1, freezing the core.
- DUMP_RD:
  - mem_owner=1, mem_read=1, mem_addr=dump_base+idx (wraps).
  - Next cycle capture mem_dout into m_data, m_valid=1, go to DUMP_OUT.
- DUMP_OUT:
  - Hold m_data/m_valid stable until m_ready.
  - On handshake, idx++; if idx==dump_len -> DONE, else DUMP_RD.
  - Throughput: one byte per 2 cycles minimum.
- DONE: done=1, cpu_start=1, mem_owner=1 until the next go or reset.
- s_valid outside LOAD is ignored; s_ready=0 there.
- Length 256 is legal: covers the full address space, wrapping from the base.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state enum (IDLE, LOAD, KICK, RUN, DUMP_RD, DUMP_OUT, DONE)
  - ADDR_W/DATA_W constants matching data_ram
  - default MAX_CYCLES
- One natural sub-module: host_cycle_counter (saturating counter with clear/enable/limit flag), reused by the top-level instruction counter.
- Address and index logic stays inline.

Test Plan:
- Reset mid-LOAD:
  - Stimulus: go with load_base=8'hF0, load_len=4; accept 2 bytes; assert start for 1 cycle.
  - Response: state IDLE, no further mem_write, cpu_start=1, busy=0.
- Load with wrap:
  - Stimulus: load_base=8'hFE, load_len=4, bytes 11,22,33,44 with s_valid gaps.
  - Response: writes to FE,FF,00,01 exactly once each; then cpu_start high for 2 cycles, then low.
- Halt ends run:
  - Stimulus: load_len=0, dump_len=0; stub core raises cpu_halt 10 cycles after cpu_start falls.
  - Response: cycles=10, timeout=0, done=1, no mem_read.
- Timeout:
  - Stimulus: MAX_CYCLES=20, cpu_halt never asserted.
  - Response: cycles=20, timeout=1, done=1.
  - Repeat with halt on the limit cycle -> timeout=0.
- Dump with backpressure:
  - Stimulus: preloaded RAM[10..12]=A1,B2,C3; dump_base=10, dump_len=3; m_ready low 5 cycles at each byte.
  - Response: m_data stable while stalled; outputs A1,B2,C3 in order; then done=1.
- Full-space dump:
  - Stimulus: dump_base=8'h80, dump_len=256.
  - Response: 256 bytes, addresses 80..FF then 00..7F; go during DUMP is ignored.
